// File: rtl/mem_rd_stream.sv
// ---------------------------------------------------------------------------
// mem_rd_stream
//
// Reads a burst of consecutive words from a synchronous memory read port and
// presents them as a valid/ready stream. A start pulse latches a base
// address and word count. Reads are issued one per cycle while credit
// remains. Returning data lands in a small FIFO of depth RD_LAT+2 that
// absorbs m_ready back-pressure.
//
// Parameters
//   WIDTH   data word width in bits
//   DEPTH   memory depth in words (AW = $clog2(DEPTH))
//   RD_LAT  memory read latency in cycles, legal range 1..3
//
// Ports
//   clk        single clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   start      one-cycle burst request; base_addr/len are sampled with it
//   base_addr  first word address
//   len        word count, 0..DEPTH
//   busy       high while a burst is in progress
//   done       one-cycle pulse when a burst completes
//   enB/addrB  memory read-port enable and address
//   doutB      memory read data, valid RD_LAT cycles after enB
//   m_data/m_valid/m_ready  output stream
//   m_last     final-word marker; exists only when MEM_RD_LAST_EN is defined
// ---------------------------------------------------------------------------
module mem_rd_stream #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int RD_LAT = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic             enB,
    output logic [AW-1:0]    addrB,
    input  logic [WIDTH-1:0] doutB,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef MEM_RD_LAST_EN
    ,
    output logic             m_last
`endif
);

    localparam int FD = RD_LAT + 2;        // FIFO depth == read credits
    localparam int PW = $clog2(FD);
    localparam int CW = $clog2(FD + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;           // next address to read
    logic [AW-1:0]     last_addr_q, last_addr_d; // address of the latest read
    logic [AW:0]       len_q, len_d;
    logic [AW:0]       issued_q, issued_d;
    logic [CW-1:0]     inflight_q, inflight_d;   // issued, not yet in FIFO
    logic [CW-1:0]     fcnt_q, fcnt_d;           // FIFO occupancy
    logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;   // tracks reads in the memory
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  fifo_mem [FD];

    logic        accept, issue, push, pop, last_pop;
    logic [CW:0] occ;

    // A start in the done cycle is not taken; the next burst begins only
    // once the completion pulse has gone.
    assign accept   = start && !done_q;
    assign pop      = (fcnt_q != '0) && m_ready;
    assign push     = vld_pipe_q[RD_LAT-1];
    // Credit check: a word leaving the FIFO this cycle frees its slot now.
    assign occ      = {1'b0, inflight_q} + {1'b0, fcnt_q} - (CW+1)'(pop);
    assign issue    = (state_q == RUN) && (issued_q < len_q) && (occ < (CW+1)'(FD));
    // Once in DRAIN every read has been issued, so a lone FIFO entry with
    // nothing left in flight is the final word of the burst.
    assign last_pop = (state_q == DRAIN) && pop && (inflight_q == '0) && (fcnt_q == CW'(1));

    // State register and datapath registers.
    // NOTE: clocked state is updated with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            inflight_q  <= '0;
            fcnt_q      <= '0;
            vld_pipe_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            inflight_q  <= inflight_d;
            fcnt_q      <= fcnt_d;
            vld_pipe_q  <= vld_pipe_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            done_q      <= done_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count define which
    // entries are meaningful, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q] <= doutB;
        end
    end

    // Next-state logic.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        len_d       = len_q;
        issued_d    = issued_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (len != '0) begin
                        state_d  = RUN;
                        len_d    = len;
                        addr_d   = base_addr;
                        issued_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue && (issued_q == len_q - (AW+1)'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            last_addr_d = addr_q;
            addr_d      = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
            issued_d    = issued_q + (AW+1)'(1);
        end

        inflight_d    = inflight_q + CW'(issue) - CW'(push);
        fcnt_d        = fcnt_q + CW'(push) - CW'(pop);
        wptr_d        = push ? ((wptr_q == PW'(FD - 1)) ? '0 : wptr_q + PW'(1)) : wptr_q;
        rptr_d        = pop  ? ((rptr_q == PW'(FD - 1)) ? '0 : rptr_q + PW'(1)) : rptr_q;
        vld_pipe_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    // Outputs. addrB shows the live address while reading and otherwise
    // holds the address of the most recent read.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = done_q;
        enB     = issue;
        addrB   = issue ? addr_q : last_addr_q;
        m_valid = (fcnt_q != '0);
        m_data  = fifo_mem[rptr_q];
`ifdef MEM_RD_LAST_EN
        m_last  = (state_q == DRAIN) && (inflight_q == '0) && (fcnt_q == CW'(1));
`endif
    end

endmodule

// File: tb/tb_mem_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_mem_rd_stream
//
// Drives two mem_rd_stream instances (RD_LAT=1 and RD_LAT=3) with shared
// burst requests and stream back-pressure. Each has its own memory read
// pipeline over a common memory image. Expected stream contents, addresses,
// first-word latency, done timing and credit bounds come from burst-level
// arithmetic (word i of a burst is mem[(base+i) % DEPTH]).
// Build with +define+MEM_RD_LAST_EN to also check m_last.
// ---------------------------------------------------------------------------
module tb_mem_rd_stream;

    localparam int WIDTH = 32;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              m_ready = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW:0]       len = '0;
    logic [1:0]        busy, done, enB, m_valid;
    logic [AW-1:0]     addrB [2];
    logic [WIDTH-1:0]  doutB [2];
    logic [WIDTH-1:0]  m_data [2];
`ifdef MEM_RD_LAST_EN
    logic [1:0]        m_last;
`endif

    mem_rd_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy[0]), .done(done[0]), .enB(enB[0]), .addrB(addrB[0]), .doutB(doutB[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready)
`ifdef MEM_RD_LAST_EN
        , .m_last(m_last[0])
`endif
    );

    mem_rd_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy[1]), .done(done[1]), .enB(enB[1]), .addrB(addrB[1]), .doutB(doutB[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready)
`ifdef MEM_RD_LAST_EN
        , .m_last(m_last[1])
`endif
    );

    always #5 clk = ~clk;

    // Memory image and per-instance read pipelines; un-enabled cycles
    // return junk so a stray capture is visible.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd0_q;
    logic [WIDTH-1:0] rd1_q [3];

    always @(posedge clk) begin
        rd0_q    <= enB[0] ? mem[addrB[0]] : $urandom;
        rd1_q[0] <= enB[1] ? mem[addrB[1]] : $urandom;
        rd1_q[1] <= rd1_q[0];
        rd1_q[2] <= rd1_q[1];
    end
    assign doutB[0] = rd0_q;
    assign doutB[1] = rd1_q[2];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset(input string name);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s/u%0d busy", name, d), busy[d], 0);
            check($sformatf("%s/u%0d done", name, d), done[d], 0);
            check($sformatf("%s/u%0d enB", name, d), enB[d], 0);
            check($sformatf("%s/u%0d addrB", name, d), addrB[d], 0);
            check($sformatf("%s/u%0d m_valid", name, d), m_valid[d], 0);
`ifdef MEM_RD_LAST_EN
            check($sformatf("%s/u%0d m_last", name, d), m_last[d], 0);
`endif
        end
    endtask

    // mode: 0 ready always, 1 ready toggling, 2 ready random,
    //       3 ready high but held low 4 cycles when word len is due (u0 view)
    // poke: a second start with different parameters mid-burst
    task automatic run_burst(input string name, input int b, input int l, input int mode,
                             input bit poke, input int exp_words, input int exp_last_addr);
        int  iss [2], pops [2], first_v [2], done_cyc [2], last_pop [2], last_iss [2];
        bit  stall_prev [2];
        logic [WIDTH-1:0] data_prev [2];
        int  held;
        int  budget;
        budget = 4 * l + 40;
        held   = 0;
        for (int d = 0; d < 2; d++) begin
            iss[d] = 0; pops[d] = 0; first_v[d] = -1; done_cyc[d] = -1;
            last_pop[d] = -10; last_iss[d] = -1; stall_prev[d] = 1'b0; data_prev[d] = '0;
        end
        @(negedge clk);
        for (int cyc = 0; ; cyc++) begin
            start     = (cyc == 0);
            base_addr = AW'(b);
            len       = (AW+1)'(l);
            if (poke && cyc == 3) begin
                start     = 1'b1;
                base_addr = AW'(b + 37);
                len       = (AW+1)'(3);
            end
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = (cyc % 2 == 1);
                2: m_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (pops[0] == l - 1 && held < 4) begin
                        m_ready = 1'b0;
                        held++;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            endcase
            #1;
            for (int d = 0; d < 2; d++) begin
                int lat;
                bit pop_now;
                bit exp_done;
                string tag;
                lat     = d ? 3 : 1;
                tag     = $sformatf("%s/lat%0d", name, lat);
                pop_now = m_valid[d] && m_ready;
                if (done_cyc[d] < 0) begin
                    if (cyc == 0) check({tag, " busy at start"}, busy[d], 0);
                    if (enB[d]) begin
                        check({tag, " addrB"}, addrB[d], (b + iss[d]) % DEPTH);
                        check({tag, " read count within len"}, iss[d] < l, 1);
                        last_iss[d] = int'(addrB[d]);
                        iss[d]++;
                    end
                    if (m_valid[d] && first_v[d] < 0) begin
                        first_v[d] = cyc;
                        check({tag, " first valid cycle"}, cyc, lat + 2);
                    end
                    if (stall_prev[d]) begin
                        check({tag, " valid held"}, m_valid[d], 1);
                        check({tag, " data held"}, m_data[d], data_prev[d]);
                    end
`ifdef MEM_RD_LAST_EN
                    if (m_valid[d]) check({tag, " m_last"}, m_last[d], pops[d] == l - 1);
                    else            check({tag, " m_last idle"}, m_last[d], 0);
`endif
                    if (pop_now) begin
                        check({tag, " m_data"}, m_data[d], mem[(b + pops[d]) % DEPTH]);
                        pops[d]++;
                        last_pop[d] = cyc;
                    end
                    check({tag, " credit bound"}, (iss[d] - pops[d]) <= lat + 2, 1);
                    exp_done = (pops[d] == l) && (last_pop[d] == cyc - 1);
                    check({tag, " done"}, done[d], exp_done);
                    if (cyc >= 1) check({tag, " busy"}, busy[d], !exp_done);
                    if (done[d]) done_cyc[d] = cyc;
                    stall_prev[d] = m_valid[d] && !m_ready;
                    data_prev[d]  = m_data[d];
                end
            end
            if (done_cyc[0] >= 0 && done_cyc[1] >= 0) break;
            if (cyc >= budget) break;
            @(negedge clk);
        end
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            string tag;
            tag = $sformatf("%s/lat%0d", name, d ? 3 : 1);
            check({tag, " done seen before timeout"}, done_cyc[d] >= 0, 1);
            check({tag, " words delivered"}, pops[d], exp_words);
            check({tag, " reads issued"}, iss[d], l);
            check({tag, " last read address"}, last_iss[d], exp_last_addr);
            if (mode == 0) check({tag, " one word per cycle"}, last_pop[d] - first_v[d], l - 1);
        end
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        bit poke;
        int exp_words;
        int exp_last_addr;
    } vec_t;

    initial begin
        vec_t vecs [8];
        int   cnt;

        vecs[0] = '{0,   4,   0, 1'b0, 4,   3};    // 0x100..0x103
        vecs[1] = '{510, 4,   0, 1'b0, 4,   1};    // 510,511,0,1
        vecs[2] = '{100, 16,  1, 1'b0, 16,  115};  // toggling ready
        vecs[3] = '{20,  5,   3, 1'b0, 5,   24};   // stall on final word
        vecs[4] = '{7,   1,   0, 1'b0, 1,   7};    // single word
        vecs[5] = '{300, 512, 0, 1'b0, 512, 299};  // full depth with wrap
        vecs[6] = '{505, 20,  2, 1'b1, 20,  12};   // random ready, ignored start
        vecs[7] = '{64,  9,   1, 1'b1, 9,   72};

        for (int a = 0; a < DEPTH; a++) mem[a] = 32'h100 + a;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_burst($sformatf("vec%0d", i), vecs[i].base, vecs[i].len, vecs[i].mode,
                      vecs[i].poke, vecs[i].exp_words, vecs[i].exp_last_addr);
        end

        // Zero-length request: done next cycle, no reads, never busy.
        @(negedge clk);
        start = 1'b1; base_addr = AW'(5); len = '0; m_ready = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("len0/u%0d done same cycle", d), done[d], 0);
            check($sformatf("len0/u%0d enB same cycle", d), enB[d], 0);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("len0/u%0d done pulse", d), done[d], 1);
            check($sformatf("len0/u%0d busy", d), busy[d], 0);
            check($sformatf("len0/u%0d enB", d), enB[d], 0);
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("len0/u%0d done after", d), done[d], 0);
                check($sformatf("len0/u%0d busy after", d), busy[d], 0);
                check($sformatf("len0/u%0d enB after", d), enB[d], 0);
            end
        end

        // Reset mid-burst after three words leave the fast instance.
        @(negedge clk);
        start = 1'b1; base_addr = '0; len = (AW+1)'(8); m_ready = 1'b1;
        cnt = 0;
        for (int cyc = 0; cyc < 50 && cnt < 3; cyc++) begin
            #1;
            if (m_valid[0] && m_ready) cnt++;
            @(negedge clk);
            start = 1'b0;
        end
        check("abort/three words before reset", cnt, 3);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset("abort");
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("abort/u%0d stale data dropped", d), m_valid[d], 0);
                check($sformatf("abort/u%0d idle", d), busy[d], 0);
            end
        end
        run_burst("after_abort", 0, 2, 0, 1'b0, 2, 1);

        // Randomized bursts over a random memory image.
        for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
        for (int k = 0; k < 20; k++) begin
            int b;
            int l;
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 24);
            run_burst($sformatf("rand%0d", k), b, l, 2, (k % 4 == 0), l, (b + l - 1) % DEPTH);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_rd_stream.md
MEM_RD_STREAM -- requirements
Module: mem_rd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 512, memory depth in words; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter RD_LAT, default 1, memory read latency in cycles; legal range 1..3.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-007 SHALL have port base_addr  input  AW  first word address, sampled with start.
REQ-008 SHALL have port len  input  AW+1  word count, 0..DEPTH, sampled with start.
REQ-009 SHALL have port busy  output  1  high from accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-011 SHALL have port enB  output  1  memory read-port enable.
REQ-012 SHALL have port addrB  output  AW  memory read-port address.
REQ-013 SHALL have port doutB  input  WIDTH  memory read data, valid RD_LAT cycles after enB.
REQ-014 SHALL have ports m_data (output, WIDTH), m_valid (output, 1), m_ready (input, 1): output stream.
REQ-015 SHALL have port m_last  output  1  final word marker (present only with MEM_RD_LAST_EN).

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN; busy = (state != IDLE).
REQ-017 IDLE: start with len>0 SHALL latch base_addr/len and enter RUN next cycle; start with len==0 SHALL pulse done next cycle, stay IDLE, issue no reads.
REQ-018 start while busy SHALL be ignored; latched parameters unchanged.
REQ-019 RUN: a read SHALL issue (enB=1, addrB=current address) in any cycle where issued<len and outstanding+fifo_count < RD_LAT+2, counting a same-cycle pop as freed.
REQ-020 Address SHALL increment by 1 per issued read and wrap from DEPTH-1 to 0.
REQ-021 enB SHALL be 0 in all cycles with no issue; addrB holds its last value.
REQ-022 doutB SHALL be captured into an internal FIFO of depth RD_LAT+2 exactly RD_LAT cycles after its enB cycle; FIFO SHALL never overflow.
REQ-023 m_valid SHALL equal FIFO non-empty; m_data = FIFO head; pop on m_valid && m_ready.
REQ-024 m_data/m_valid SHALL stay stable while m_valid && !m_ready.
REQ-025 After the len-th issue SHALL enter DRAIN; when the last word pops SHALL pulse done for one cycle and return to IDLE.
REQ-026 With m_ready held high, SHALL sustain one word per cycle; first m_valid exactly RD_LAT+2 cycles after the cycle start is sampled.
REQ-027 A new start SHALL be accepted in the cycle done is high? No: only from the cycle after done (state IDLE).

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, enB=0, addrB=0, m_valid=0, m_last=0, FIFO empty, counters 0.
REQ-029 Reset mid-burst SHALL abort; read data returning after reset SHALL be discarded.

Configuration
REQ-030 Macro MEM_RD_LAST_EN defined: m_last SHALL be 1 exactly with the len-th word of a burst while m_valid=1, else 0.
REQ-031 Macro MEM_RD_LAST_EN undefined: m_last port and its tracking logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 RD_LAT=1, base=0, len=4, m_ready=1, mem[i]=i+0x100 -> m_data 0x100..0x103 on consecutive cycles, first valid 3 cycles after start, done one cycle after last pop.
REQ-033 base=510, len=4, DEPTH=512 -> addrB sequence 510,511,0,1.
REQ-034 RD_LAT=3, len=16, m_ready toggling 1/0 -> all 16 words in order, no loss/duplication, FIFO count never exceeds 5.
REQ-035 start with len=0 -> done pulse next cycle, enB never asserted, busy stays 0.
REQ-036 rst_n=0 asserted after 3 of 8 words -> all outputs at reset values next cycle; subsequent start base=0,len=2 -> exactly 2 correct words.
REQ-037 MEM_RD_LAST_EN defined, len=5, m_ready stalled on word 5 -> m_last=1 held with word 5 until popped.
